tick_reducer: RTL and testbench

//  Programmable clock-enable generator for the processor's slow-tick domain.

---
 rtl/tick_reducer.sv | 109 ++++++++++
 tb/tb_tick_reducer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tick_reducer.sv
// rtl/tick_reducer.sv - programmable pulse/square clock-enable divider for the slow-tick domain
// Optional REDUCER_TICK_COUNT_EN builds a 16-bit terminal-count counter on tick_count.
module tick_reducer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(32'h00FFFFFF),
  parameter logic             DEFAULT_MODE = 1'b0
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_mode,
  output logic             div_ack,
  output logic             clock_out,
  output logic [15:0]      tick_count
);

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] shadow_div;
  logic             shadow_mode;
  logic             pending;

  logic             tc;
  logic             apply;
  logic [WIDTH-1:0] cnt_next;
  logic             out_next;

  assign tc    = enable && (cnt == div_reg);
  // A pending load lands on a TC edge, or immediately while the counter is frozen.
  assign apply = pending && (tc || !enable);

  always_comb begin
    cnt_next = cnt;
    if (tc || apply) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_comb begin
    out_next = clock_out;
    if (mode_reg == MODE_PULSE) begin
      out_next = tc;
    end else if (tc) begin
      out_next = ~clock_out;
    end
    // Mode changes: entering pulse drops the output, entering square keeps the level.
    if (apply) begin
      if (shadow_mode == MODE_PULSE && mode_reg == MODE_SQUARE) begin
        out_next = 1'b0;
      end else if (shadow_mode == MODE_SQUARE && mode_reg == MODE_PULSE) begin
        out_next = clock_out;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt         <= '0;
      div_reg     <= DEFAULT_DIV;
      mode_reg    <= DEFAULT_MODE;
      shadow_div  <= DEFAULT_DIV;
      shadow_mode <= DEFAULT_MODE;
      pending     <= 1'b0;
      div_ack     <= 1'b0;
      clock_out   <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      clock_out <= out_next;
      div_ack   <= apply;
      if (apply) begin
        div_reg  <= shadow_div;
        mode_reg <= shadow_mode;
      end
      // A load in the apply cycle re-arms with the new value after the old one lands.
      if (div_load) begin
        shadow_div  <= div_value;
        shadow_mode <= div_mode;
        pending     <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef REDUCER_TICK_COUNT_EN
  logic [15:0] tick_q;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      tick_q <= 16'h0000;
    end else if (tc) begin
      tick_q <= tick_q + 16'h0001;
    end
  end

  assign tick_count = tick_q;
`else
  assign tick_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tick_reducer.sv
// tb/tb_tick_reducer.sv - vector table, corner sequences and random run against a reference model
module tb_tick_reducer;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_value = 8'd0;
  logic       div_mode = 1'b0;
  logic       div_ack;
  logic       clock_out;
  logic [15:0] tick_count;

  int checks = 0;
  int errors = 0;

  int m_cnt, m_div, m_ticks, m_sh_div;
  bit m_mode, m_out, m_ack, m_pend, m_sh_mode;

  typedef struct {
    bit       en;
    bit       ld;
    bit [7:0] val;
    bit       md;
    bit       exp_out;
    bit       exp_ack;
  } vec_t;

  vec_t vecs[26];

  tick_reducer #(
    .WIDTH(8),
    .DEFAULT_DIV(8'd4),
    .DEFAULT_MODE(1'b0)
  ) dut (
    .clock_in(clock_in),
    .reset(reset),
    .enable(enable),
    .div_load(div_load),
    .div_value(div_value),
    .div_mode(div_mode),
    .div_ack(div_ack),
    .clock_out(clock_out),
    .tick_count(tick_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_ticks();
`ifdef REDUCER_TICK_COUNT_EN
    return m_ticks;
`else
    return 0;
`endif
  endfunction

  // Reference: counter runs modulo (div+1); loads wait in a shadow until TC or freeze.
  task automatic model_step(input bit rst, input bit en, input bit ld, input int val, input bit md);
    bit tc, apply, old_out;
    if (rst) begin
      m_cnt = 0; m_div = 4; m_mode = 0; m_out = 0; m_ack = 0; m_ticks = 0; m_pend = 0;
      return;
    end
    tc = en && (m_cnt == m_div);
    apply = m_pend && (tc || !en);
    old_out = m_out;
    if (m_mode == 0) m_out = tc;
    else if (tc) m_out = !m_out;
    if (apply && m_sh_mode == 0 && m_mode == 1) m_out = 0;
    if (apply && m_sh_mode == 1 && m_mode == 0) m_out = old_out;
    if (en) m_cnt = (m_cnt + 1) % (m_div + 1);
    if (apply) m_cnt = 0;
    if (tc) m_ticks = (m_ticks + 1) % 65536;
    m_ack = apply;
    if (apply) begin
      m_div = m_sh_div; m_mode = m_sh_mode; m_pend = 0;
    end
    if (ld) begin
      m_sh_div = val; m_sh_mode = md; m_pend = 1;
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit ld, input int val, input bit md);
    reset = rst; enable = en; div_load = ld; div_value = val[7:0]; div_mode = md;
    @(posedge clock_in);
    model_step(rst, en, ld, val, md);
    #1;
    check("model_out", {31'd0, clock_out}, {31'd0, m_out});
    check("model_ack", {31'd0, div_ack}, {31'd0, m_ack});
    check("model_ticks", {16'd0, tick_count}, exp_ticks());
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    check("reset_out", {31'd0, clock_out}, 0);
    check("reset_ack", {31'd0, div_ack}, 0);
    check("reset_ticks", {16'd0, tick_count}, 0);
  endtask

  initial begin
    int acks;
    bit e_out;

    for (int i = 0; i < 26; i++) begin
      vecs[i].en = 1;
      vecs[i].ld = (i == 15);
      vecs[i].val = 8'd1;
      vecs[i].md = 1;
      vecs[i].exp_out = (i == 4 || i == 9 || i == 14 || i == 21 || i == 22 || i == 25);
      vecs[i].exp_ack = (i == 19);
    end

    // Pulse from reset, then a mid-count load into square mode with divisor 1.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      step(0, vecs[i].en, vecs[i].ld, vecs[i].val, vecs[i].md);
      check($sformatf("vec%0d_out", i), {31'd0, clock_out}, {31'd0, vecs[i].exp_out});
      check($sformatf("vec%0d_ack", i), {31'd0, div_ack}, {31'd0, vecs[i].exp_ack});
      if (i == 14) begin
`ifdef REDUCER_TICK_COUNT_EN
        check("s1_ticks", {16'd0, tick_count}, 3);
`else
        check("s1_ticks", {16'd0, tick_count}, 0);
`endif
      end
    end

    // Load coincident with TC, overwritten before the next TC.
    do_reset();
    acks = 0;
    for (int e = 1; e <= 16; e++) begin
      step(0, 1, (e == 5 || e == 6), (e == 5) ? 3 : 2, 0);
      acks += div_ack;
      e_out = (e == 5 || e == 10 || e == 13 || e == 16);
      check($sformatf("s3_out_e%0d", e), {31'd0, clock_out}, {31'd0, e_out});
      check($sformatf("s3_ack_e%0d", e), {31'd0, div_ack}, {31'd0, (e == 10)});
    end
    check("s3_ack_count", acks, 1);

    // Square wave frozen by enable=0, loaded while frozen.
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      step(0, !(e <= 2 || (e >= 7 && e <= 13)), (e == 1), 2, 1);
      check($sformatf("s4sq_out_e%0d", e), {31'd0, clock_out}, {31'd0, (e >= 5 && e <= 14)});
      check($sformatf("s4sq_ack_e%0d", e), {31'd0, div_ack}, {31'd0, (e == 2)});
    end

    // Pulse mode freeze resumes from the held count.
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      step(0, !(e >= 3 && e <= 9), 0, 0, 0);
      check($sformatf("s4pl_out_e%0d", e), {31'd0, clock_out}, {31'd0, (e == 12)});
    end

    // Load with enable=0 applies on the next edge; divisor 0 holds the pulse high.
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      step(0, (e >= 3), (e == 1), 0, 0);
      check($sformatf("s5_out_e%0d", e), {31'd0, clock_out}, {31'd0, (e >= 3)});
      check($sformatf("s5_ack_e%0d", e), {31'd0, div_ack}, {31'd0, (e == 2)});
    end

    // Reset with a load pending and the output high discards the load.
    do_reset();
    for (int e = 1; e <= 5; e++) step(0, 1, (e == 5), 1, 1);
    check("s6_out_before", {31'd0, clock_out}, 1);
    step(1, 1, 0, 0, 0);
    check("s6_out_reset", {31'd0, clock_out}, 0);
    check("s6_ack_reset", {31'd0, div_ack}, 0);
    check("s6_ticks_reset", {16'd0, tick_count}, 0);
    acks = 0;
    for (int e = 1; e <= 12; e++) begin
      step(0, 1, 0, 0, 0);
      acks += div_ack;
      check($sformatf("s6_out_e%0d", e), {31'd0, clock_out}, {31'd0, (e == 5 || e == 10)});
    end
    check("s6_no_ack", acks, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 6)),
           bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
